// File: rtl/operand_gather6.sv
// Serial-to-parallel collector: packs up to six operands per group into one of two
// ping-pong banks and presents completed groups, in order, on six parallel buses.
module operand_gather6 #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [WIDTH-1:0] out_e,
  output logic [WIDTH-1:0] out_f,
  output logic [2:0]       out_count
);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_st_e;

  bank_st_e         st_q   [2];
  bank_st_e         st_d   [2];
  logic [2:0]       cnt_q  [2];
  logic [2:0]       cnt_d  [2];
  logic [WIDTH-1:0] slot_q [2][6];
  logic [WIDTH-1:0] slot_d [2][6];
  logic             wp_q, wp_d;
  logic             rp_q, rp_d;
  logic             acc, xfer, close;

  assign in_ready  = (st_q[wp_q] != StFull);
  assign out_valid = (st_q[rp_q] == StFull);
  assign out_a     = slot_q[rp_q][0];
  assign out_b     = slot_q[rp_q][1];
  assign out_c     = slot_q[rp_q][2];
  assign out_d     = slot_q[rp_q][3];
  assign out_e     = slot_q[rp_q][4];
  assign out_f     = slot_q[rp_q][5];
  assign out_count = cnt_q[rp_q];

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    slot_d = slot_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    acc    = in_valid && in_ready;
    xfer   = out_valid && out_ready;
    close  = 1'b0;

    // A transfer needs bank[rp] FULL and an accept needs bank[wp] not FULL, so when both
    // happen they always touch different banks.
    if (xfer) begin
      st_d[rp_q]  = StEmpty;
      cnt_d[rp_q] = '0;
      for (int i = 0; i < 6; i++) begin
        slot_d[rp_q][i] = '0;
      end
      rp_d = ~rp_q;
    end

    if (acc) begin
      slot_d[wp_q][cnt_q[wp_q]] = in_data;
      cnt_d[wp_q] = cnt_q[wp_q] + 3'd1;
      st_d[wp_q]  = StFilling;
      close       = (cnt_q[wp_q] == 3'd5) || flush;
    end else if (flush && in_ready && (st_q[wp_q] == StFilling)) begin
      close = 1'b1;
    end

    if (close) begin
      st_d[wp_q] = StFull;
      wp_d       = ~wp_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= StEmpty;
        cnt_q[b] <= '0;
        for (int i = 0; i < 6; i++) begin
          slot_q[b][i] <= '0;
        end
      end
      wp_q <= 1'b0;
      rp_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
    end
  end

endmodule
